// File: rtl/vga_if.sv
// vga_if: bundle of the signals driven from the VGA timing core toward the
// connector pins.
//   r, g, b        RGB332 colour (3/3/2 bits), zero while blanking
//   hs, vs         horizontal / vertical sync, active-low
//   hcount, vcount raw pixel (0..799) and line (0..524) counters
// master: the timing generator, which drives everything.
// slave : the pins or any observer, which only reads.
interface vga_if;
  logic [2:0] r;
  logic [2:0] g;
  logic [1:0] b;
  logic       hs;
  logic       vs;
  logic [9:0] hcount;
  logic [9:0] vcount;

  modport master (output r, g, b, hs, vs, hcount, vcount);
  modport slave  (input  r, g, b, hs, vs, hcount, vcount);
endinterface

// File: rtl/vga_core.sv
// vga_core: 640x480@60Hz VGA timing generator with a colour-bar test pattern.
// Runs on the 50 MHz system clock. An internal divide-by-2 enable gives the
// 25 MHz pixel rate, so one pixel spans two clk cycles.
// Ports:
//   clk  in   50 MHz system clock
//   rst  in   synchronous reset, active-high
//   vga  out  vga_if.master: r/g/b (RGB332), hs/vs (active-low),
//             hcount/vcount (raw counters)
// Sync and colour are combinational decodes of the counter registers, so
// they line up with hcount/vcount with no added latency.
module vga_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BAR_W    = 80
) (
  input  logic  clk,
  input  logic  rst,
  vga_if.master vga
);

  localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] BAR_W_L  = 10'(BAR_W);

  logic       pe;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       active;
  logic [7:0] rgb;

  // Bar index selects the colour: each index bit is replicated across one
  // channel, so bar 0 is black and bar 7 is white.
  function automatic logic [7:0] bar_colour(input logic [9:0] h);
    logic [2:0] idx;
    idx = 3'(h / BAR_W_L);
    return {{3{idx[2]}}, {3{idx[1]}}, {2{idx[0]}}};
  endfunction

  // Pixel enable and raw counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pe    <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      pe <= ~pe;
      if (pe) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // Zero-latency decode of sync and colour from the counters
  always_comb begin
    active = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
    rgb    = active ? bar_colour(h_cnt) : 8'h00;
  end

  assign vga.hs     = ~((h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E));
  assign vga.vs     = ~((v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E));
  assign vga.r      = rgb[7:5];
  assign vga.g      = rgb[4:2];
  assign vga.b      = rgb[1:0];
  assign vga.hcount = h_cnt;
  assign vga.vcount = v_cnt;

endmodule

// File: tb/tb_vga_core.sv
// Directed bench for vga_core. dut_a uses the full 640x480 timing; dut_b keeps
// the same horizontal timing but a 10-line frame (4 active, FP 2, sync 2,
// BP 2) so vertical sync, frame wrap and blanking below the active area fit in
// a short run. Both share clk and rst and run in lockstep; cyc counts clk
// edges since reset release.
module tb_vga_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  vga_if vif_a ();
  vga_if vif_b ();

  vga_core dut_a (.clk(clk), .rst(rst), .vga(vif_a));

  vga_core #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_b (
    .clk(clk), .rst(rst), .vga(vif_b)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int t);
    while (cyc < t) tick();
  endtask

  function automatic logic [7:0] rgb_a();
    return {vif_a.r, vif_a.g, vif_a.b};
  endfunction

  function automatic logic [7:0] rgb_b();
    return {vif_b.r, vif_b.g, vif_b.b};
  endfunction

  // Expected colour at a horizontal position on an active line, derived from
  // the bar number independently of the DUT.
  function automatic logic [7:0] exp_bar(input int h);
    logic [7:0] tbl [8];
    tbl = '{8'h00, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF};
    return tbl[h / 80];
  endfunction

  initial begin
    // Reset held for 3 clk
    rst = 1'b1;
    tick();
    check("rst_h1", vif_a.hcount, 0);
    tick(); tick();
    check("rst_h", vif_a.hcount, 0);
    check("rst_v", vif_a.vcount, 0);
    check("rst_hs", vif_a.hs, 1);
    check("rst_vs", vif_a.vs, 1);
    check("rst_rgb", rgb_a(), 8'h00);

    rst = 1'b0;
    cyc = 0;
    go(1);    check("h_after1", vif_a.hcount, 0);
    go(2);    check("h_after2", vif_a.hcount, 1);
    go(3);    check("h_after3", vif_a.hcount, 1);
    go(158);  check("bar0_h79", rgb_a(), exp_bar(79));
    go(160);  check("bar1_h80", rgb_a(), 8'h03);
    go(320);  check("bar2_h160", rgb_a(), 8'h1C);
    go(800);  check("bar5_h400", rgb_a(), 8'hE3);
    go(1278); check("bar7_h639", rgb_a(), 8'hFF);
    go(1280); check("blank_h640", rgb_a(), 8'h00);
    go(1311); check("hs_pre", vif_a.hs, 1);
              check("h_655", vif_a.hcount, 655);
    go(1312); check("hs_fall", vif_a.hs, 0);
              check("rgb_sync", rgb_a(), 8'h00);
    go(1503); check("hs_last", vif_a.hs, 0);
    go(1504); check("hs_rise", vif_a.hs, 1);
    go(1598); check("h_799", vif_a.hcount, 799);
              check("v_line0", vif_a.vcount, 0);
              check("rgb_h799", rgb_a(), 8'h00);
    go(1600); check("h_wrap", vif_a.hcount, 0);
              check("v_inc", vif_a.vcount, 1);
              check("rgb_l1_h0", rgb_a(), 8'h00);
    go(2911); check("hs_l1_pre", vif_a.hs, 1);
    go(2912); check("hs_l1_fall", vif_a.hs, 0);

    // Line 4: active on dut_a, blanked on dut_b (below its active area)
    go(7200); check("a_l4_bar5", rgb_a(), 8'hE3);
              check("b_l4_blank", rgb_b(), 8'h00);
              check("b_v4", vif_b.vcount, 4);

    // dut_b vertical sync during lines 6..7
    go(9599);  check("vs_pre", vif_b.vs, 1);
    go(9600);  check("vs_fall", vif_b.vs, 0);
               check("vs_a_high", vif_a.vs, 1);
    go(12799); check("vs_last", vif_b.vs, 0);
    go(12800); check("vs_rise", vif_b.vs, 1);

    // dut_b frame wrap after 16000 clk; dut_a continues to line 10
    go(15998); check("b_v9", vif_b.vcount, 9);
               check("b_h799", vif_b.hcount, 799);
    go(16000); check("b_vwrap", vif_b.vcount, 0);
               check("b_hwrap", vif_b.hcount, 0);
               check("a_v10", vif_a.vcount, 10);
    go(16160); check("b_f2_bar1", rgb_b(), 8'h03);

    // Mid-frame reset while both syncs of dut_b are low
    go(27000); check("pre_b_v", vif_b.vcount, 6);
               check("pre_b_hs", vif_b.hs, 0);
               check("pre_b_vs", vif_b.vs, 0);
               check("pre_a_v", vif_a.vcount, 16);
    rst = 1'b1;
    tick();
    check("mrst_a_h", vif_a.hcount, 0);
    check("mrst_a_v", vif_a.vcount, 0);
    check("mrst_a_hs", vif_a.hs, 1);
    check("mrst_b_vs", vif_b.vs, 1);
    check("mrst_b_v", vif_b.vcount, 0);
    check("mrst_rgb", rgb_a(), 8'h00);
    rst = 1'b0;
    cyc = 0;
    go(1);   check("rel_h0", vif_a.hcount, 0);
    go(2);   check("rel_h1", vif_a.hcount, 1);
             check("rel_v0", vif_b.vcount, 0);
    go(160); check("rel_bar1", rgb_a(), 8'h03);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Safety limit so the run always ends
  initial begin
    #5ms;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
